// File: rtl/free_list_pkg.sv
// free_list_pkg: core rename constants, physical register type and
// the modulo-DEPTH pointer helper shared by the free list.
package free_list_pkg;

  localparam int N_PREG  = 64;
  localparam int N_AREG  = 32;
  localparam int N_ALLOC = 2;
  localparam int N_FREE  = 2;

  localparam int DEPTH  = N_PREG - N_AREG;
  localparam int PREG_W = $clog2(N_PREG);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // DEPTH need not be a power of two, so wrap explicitly
  function automatic ptr_t ptr_add(ptr_t p, cnt_t inc);
    logic [CNT_W:0] s;
    s = (CNT_W+1)'(p) + (CNT_W+1)'(inc);
    if (s >= (CNT_W+1)'(DEPTH))
      s = s - (CNT_W+1)'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/free_list_if.sv
// free_list_if: rename allocation and commit free bundle
// between the core (master) and the free list (slave).
interface free_list_if;
  import free_list_pkg::*;

  logic [N_ALLOC-1:0]        alloc_req;
  logic                      alloc_ready;
  logic [N_ALLOC*PREG_W-1:0] alloc_id;
  logic [N_FREE-1:0]         free_en;
  logic [N_FREE*PREG_W-1:0]  free_id;
  cnt_t                      count;
  logic                      dup_err;

  modport master (
    output alloc_req, free_en, free_id,
    input  alloc_ready, alloc_id, count, dup_err
  );

  modport slave (
    input  alloc_req, free_en, free_id,
    output alloc_ready, alloc_id, count, dup_err
  );

endinterface

// File: rtl/free_list_prefix_popcount.sv
// prefix_popcount: exclusive prefix set-bit counts per position
// plus total, used to compact alloc and free slots.
module prefix_popcount #(
  parameter  int N  = 2,
  localparam int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]    i_vec,
  output logic [N*CW-1:0] o_pre,
  output logic [CW-1:0]   o_total
);

  logic [CW-1:0] w_acc;

  always_comb begin
    w_acc = '0;
    o_pre = '0;
    for (int i = 0; i < N; i++) begin
      o_pre[i*CW +: CW] = w_acc;
      w_acc = w_acc + CW'(i_vec[i]);
    end
    o_total = w_acc;
  end

endmodule

// File: rtl/free_list.sv
// free_list: multi-port circular free list of physical register IDs.
// Optional FREE_LIST_DUPCHK_EN drops duplicate frees and flags dup_err.
module free_list
  import free_list_pkg::*;
(
  input logic      clk,
  input logic      reset,
  free_list_if.slave bus
);

  localparam int ACW = $clog2(N_ALLOC + 1);
  localparam int FCW = $clog2(N_FREE + 1);

  preg_t r_entry [DEPTH];
  ptr_t  r_head;
  ptr_t  r_tail;
  cnt_t  r_count;

  logic                 w_alloc_ready;
  logic                 w_alloc_fire;
  cnt_t                 w_alloc_n;
  logic [N_ALLOC*ACW-1:0] w_apre;
  logic [ACW-1:0]       w_atot;
  preg_t                w_aid [N_ALLOC];

  logic [N_FREE-1:0]     w_free_ok;
  logic [N_FREE*FCW-1:0] w_fpre;
  logic [FCW-1:0]        w_ftot;
  preg_t                 w_fid   [N_FREE];
  ptr_t                  w_fslot [N_FREE];
  logic                  w_ovf;
  logic                  w_dup;

`ifdef FREE_LIST_DUPCHK_EN
  logic [N_PREG-1:0] r_in_list;
  logic              r_dup_err;
`endif

  prefix_popcount #(.N(N_ALLOC)) u_apc (
    .i_vec  (bus.alloc_req),
    .o_pre  (w_apre),
    .o_total(w_atot)
  );

  assign w_alloc_ready = r_count >= CNT_W'(N_ALLOC);
  assign w_alloc_fire  = w_alloc_ready && |bus.alloc_req;
  assign w_alloc_n     = w_alloc_fire ? CNT_W'(w_atot) : '0;

  assign bus.alloc_ready = w_alloc_ready;
  assign bus.count       = r_count;

  always_comb begin
    bus.alloc_id = '0;
    for (int i = 0; i < N_ALLOC; i++) begin
      w_aid[i] = r_entry[ptr_add(r_head,
                   CNT_W'(w_apre[i*ACW +: ACW]))];
      bus.alloc_id[i*PREG_W +: PREG_W] = w_aid[i];
    end
  end

  // Accept frees in port order; higher ports drop first on overflow
  always_comb begin
    logic [CNT_W:0] n;
    logic           dup;
    w_free_ok = '0;
    w_ovf     = 1'b0;
    w_dup     = 1'b0;
    n         = (CNT_W+1)'(r_count);
    dup       = 1'b0;
    for (int j = 0; j < N_FREE; j++)
      w_fid[j] = bus.free_id[j*PREG_W +: PREG_W];
    for (int j = 0; j < N_FREE; j++) begin
      if (bus.free_en[j]) begin
`ifdef FREE_LIST_DUPCHK_EN
        dup = r_in_list[w_fid[j]];
        for (int k = 0; k < j; k++)
          if (bus.free_en[k] && w_fid[k] == w_fid[j])
            dup = 1'b1;
`else
        dup = 1'b0;
`endif
        if (dup) begin
          w_dup = 1'b1;
        end else if (n >= (CNT_W+1)'(DEPTH)) begin
          w_ovf = 1'b1;
        end else begin
          w_free_ok[j] = 1'b1;
          n = n + 1'b1;
        end
      end
    end
  end

  prefix_popcount #(.N(N_FREE)) u_fpc (
    .i_vec  (w_free_ok),
    .o_pre  (w_fpre),
    .o_total(w_ftot)
  );

  always_comb begin
    for (int j = 0; j < N_FREE; j++)
      w_fslot[j] = ptr_add(r_tail,
                     CNT_W'(w_fpre[j*FCW +: FCW]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++)
        r_entry[k] <= PREG_W'(N_AREG + k);
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= CNT_W'(DEPTH);
    end else begin
      for (int j = 0; j < N_FREE; j++)
        if (w_free_ok[j])
          r_entry[w_fslot[j]] <= w_fid[j];
      r_head  <= ptr_add(r_head, w_alloc_n);
      r_tail  <= ptr_add(r_tail, CNT_W'(w_ftot));
      r_count <= r_count - w_alloc_n + CNT_W'(w_ftot);
    end
  end

`ifdef FREE_LIST_DUPCHK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < N_PREG; b++)
        r_in_list[b] <= (b >= N_AREG);
      r_dup_err <= 1'b0;
    end else begin
      for (int i = 0; i < N_ALLOC; i++)
        if (w_alloc_fire && bus.alloc_req[i])
          r_in_list[w_aid[i]] <= 1'b0;
      for (int j = 0; j < N_FREE; j++)
        if (w_free_ok[j])
          r_in_list[w_fid[j]] <= 1'b1;
      if (w_dup || w_ovf)
        r_dup_err <= 1'b1;
    end
  end

  assign bus.dup_err = r_dup_err;
`else
  // w_dup is constant 0 here, so this ties dup_err low
  assign bus.dup_err = w_dup;
`endif

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset) !w_ovf);

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed vector table plus randomized run checked
// against a queue model of the free list.
module tb_free_list;
  import free_list_pkg::*;

`ifdef FREE_LIST_DUPCHK_EN
  localparam bit DUPCHK = 1'b1;
`else
  localparam bit DUPCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  free_list_if bus();

  free_list u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit [1:0] req;
    bit [1:0] fen;
    int       f0;
    int       f1;
    bit       rdy;
    int       id0;
    int       id1;
    int       cnt;
    bit       dup;
  } vec_t;

  vec_t vq[$];
  preg_t ml[$];
  preg_t pool[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void add(bit rst, bit [1:0] req, bit [1:0] fen,
                              int f0, int f1, bit rdy,
                              int id0, int id1, int cnt, bit dup);
    vec_t v;
    v.rst = rst; v.req = req; v.fen = fen; v.f0 = f0; v.f1 = f1;
    v.rdy = rdy; v.id0 = id0; v.id1 = id1; v.cnt = cnt; v.dup = dup;
    vq.push_back(v);
  endfunction

  task automatic drive(bit rst, bit [1:0] req, bit [1:0] fen,
                       int f0, int f1);
    reset         = rst;
    bus.alloc_req = req;
    bus.free_en   = fen;
    bus.free_id   = {PREG_W'(f1), PREG_W'(f0)};
  endtask

  initial begin
    vec_t     v;
    bit [1:0] req;
    bit [1:0] fen;
    int       fid [2];
    int       k;
    int       nf_max;
    int       idx;
    bit       rdy;

    drive(1'b1, 2'b00, 2'b00, 0, 0);
    @(posedge clk); #1;

    // two full groups after reset
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 2'b11, 0, 0, 0, 1, 32, 33, 32, 0);
    add(0, 2'b11, 0, 0, 0, 1, 34, 35, 30, 0);
    add(0, 2'b00, 0, 0, 0, 1, 0, 0, 28, 0);
    // single-slot compaction, then drain to empty
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 2'b10, 0, 0, 0, 1, 0, 32, 32, 0);
    add(0, 2'b01, 0, 0, 0, 1, 33, 0, 31, 0);
    add(0, 2'b11, 0, 0, 0, 1, 34, 35, 30, 0);
    for (int i = 0; i < 14; i++)
      add(0, 2'b11, 0, 0, 0, 1, 36 + 2*i, 37 + 2*i, 28 - 2*i, 0);
    add(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
    // refill while empty, then alloc and free together
    add(0, 2'b00, 2'b11, 5, 9, 0, 0, 0, 0, 0);
    add(0, 2'b11, 2'b11, 40, 41, 1, 5, 9, 2, 0);
    add(0, 2'b11, 0, 0, 0, 1, 40, 41, 2, 0);
    add(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    // free of an ID still in the list
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 2'b11, 0, 0, 0, 1, 32, 33, 32, 0);
    add(0, 2'b00, 2'b01, 50, 0, 1, 0, 0, 30, 0);
    add(0, 2'b00, 0, 0, 0, 1, 0, 0, DUPCHK ? 30 : 31, DUPCHK);
    add(0, 2'b00, 0, 0, 0, 1, 0, 0, DUPCHK ? 30 : 31, DUPCHK);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 2'b00, 0, 0, 0, 1, 0, 0, 32, 0);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      drive(v.rst, v.req, v.fen, v.f0, v.f1);
      @(negedge clk);
      if (!v.rst) begin
        chk($sformatf("v%0d ready", i), 32'(bus.alloc_ready), 32'(v.rdy));
        chk($sformatf("v%0d count", i), 32'(bus.count), v.cnt);
        chk($sformatf("v%0d dup", i), 32'(bus.dup_err), 32'(v.dup));
        if (v.rdy && v.req[0])
          chk($sformatf("v%0d id0", i), 32'(bus.alloc_id[5:0]), v.id0);
        if (v.rdy && v.req[1])
          chk($sformatf("v%0d id1", i), 32'(bus.alloc_id[11:6]), v.id1);
      end
      @(posedge clk); #1;
    end

    // randomized run against a FIFO-of-IDs model
    drive(1'b1, 2'b00, 2'b00, 0, 0);
    @(posedge clk); #1;
    ml.delete();
    pool.delete();
    for (int i = 0; i < DEPTH; i++) ml.push_back(preg_t'(N_AREG + i));
    for (int i = 0; i < N_AREG; i++) pool.push_back(preg_t'(i));

    for (int c = 0; c < 600; c++) begin
      req    = 2'($urandom_range(0, 3));
      fen    = 2'($urandom_range(0, 3));
      nf_max = DEPTH - ml.size();
      if (pool.size() < nf_max) nf_max = pool.size();
      while ($countones(fen) > nf_max)
        fen = fen[1] ? 2'(fen & 2'b01) : 2'b00;
      fid[0] = 0;
      fid[1] = 0;
      for (int j = 0; j < 2; j++)
        if (fen[j]) begin
          idx = $urandom_range(0, pool.size() - 1);
          fid[j] = int'(pool[idx]);
          pool.delete(idx);
        end
      drive(1'b0, req, fen, fid[0], fid[1]);
      @(negedge clk);
      rdy = ml.size() >= N_ALLOC;
      chk("rnd count", 32'(bus.count), ml.size());
      chk("rnd ready", 32'(bus.alloc_ready), 32'(rdy));
      chk("rnd dup", 32'(bus.dup_err), 0);
      if (rdy) begin
        k = 0;
        for (int i = 0; i < N_ALLOC; i++)
          if (req[i]) begin
            chk($sformatf("rnd id%0d", i),
                32'(bus.alloc_id[i*PREG_W +: PREG_W]), 32'(ml[k]));
            k++;
          end
        for (int i = 0; i < k; i++) pool.push_back(ml.pop_front());
      end
      for (int j = 0; j < 2; j++)
        if (fen[j]) ml.push_back(preg_t'(fid[j]));
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
